// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Write-back store queue between the MEM stage and the data
//                memory port. Buffers up to DEPTH stores, drains one per
//                cycle when the port is not needed by a load, forwards
//                exact-match data to loads and stalls partially overlapping
//                loads.
//                Optional macro STORE_BUFFER_COALESCE_EN: a store to the
//                youngest entry's address (when that entry is not draining)
//                overwrites its data in place instead of allocating.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        st_valid_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    output logic        st_ready_o,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_addr_i,
    output logic        ld_hit_o,
    output logic        ld_stall_o,
    output logic [31:0] ld_data_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wrdata_o,
    output logic        mem_wr_o,
    output logic        mem_rd_o,
    output logic        empty_o,
    output logic        full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]  r_addr [DEPTH];
    logic [31:0]    r_data [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [PW:0]    r_count;

    logic           w_empty;
    logic           w_full;
    logic [AW-1:0]  w_ld_a;
    logic [PW-1:0]  w_off   [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_eq;
    logic [DEPTH-1:0] w_ovl;
    logic           w_exact;
    logic [PW-1:0]  w_best_off;
    logic [31:0]    w_fwd_data;
    logic           w_overlap;
    logic           w_ld_hit;
    logic           w_ld_stall;
    logic           w_ld_miss;
    logic           w_drain;
    logic           w_coal;
    logic           w_push;
    logic           w_unused;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_ld_a  = ld_addr_i[AW-1:0];

    // Upper store-address bits are not decoded by the data memory
    assign w_unused = &{1'b0, st_addr_i[31:AW]};

    // Per-slot validity (age relative to head) and address comparisons
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [AW-1:0] w_dlo;
        logic [AW-1:0] w_dhi;
        assign w_off[i]   = PW'(i) - r_head;
        assign w_valid[i] = ({1'b0, w_off[i]} < r_count);
        assign w_dlo      = w_ld_a - r_addr[i];
        assign w_dhi      = r_addr[i] - w_ld_a;
        assign w_eq[i]    = w_valid[i] && (r_addr[i] == w_ld_a);
        assign w_ovl[i]   = w_valid[i] &&
                            (((w_dlo >= AW'(1)) && (w_dlo <= AW'(3))) ||
                             ((w_dhi >= AW'(1)) && (w_dhi <= AW'(3))));
    end

    // Pick the youngest exact match (largest age offset from head)
    always_comb begin
        w_exact    = 1'b0;
        w_best_off = '0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_eq[i] && (!w_exact || (w_off[i] > w_best_off))) begin
                w_exact    = 1'b1;
                w_best_off = w_off[i];
                w_fwd_data = r_data[i];
            end
        end
    end

    assign w_overlap  = |w_ovl;
    assign w_ld_stall = ld_valid_i && w_overlap;
    assign w_ld_hit   = ld_valid_i && w_exact && !w_overlap;
    assign w_ld_miss  = ld_valid_i && !w_exact && !w_overlap;

    // Drain whenever the port is not claimed by a missing load
    assign w_drain = !w_empty && !w_ld_miss;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] w_tail_m1;
    assign w_tail_m1 = r_tail - PW'(1);
    // The youngest entry may only be merged into if it is not leaving now
    assign w_coal = !w_empty &&
                    (st_addr_i[AW-1:0] == r_addr[w_tail_m1]) &&
                    !(w_drain && (r_count == (PW+1)'(1)));
`else
    assign w_coal = 1'b0;
`endif

    assign st_ready_o = !w_full || w_coal;
    assign w_push     = st_valid_i && !w_full && !w_coal;

    assign ld_hit_o     = w_ld_hit;
    assign ld_stall_o   = w_ld_stall;
    assign ld_data_o    = w_ld_hit ? w_fwd_data : '0;
    assign mem_wr_o     = w_drain;
    assign mem_rd_o     = w_ld_miss;
    assign mem_addr_o   = w_drain   ? {{(32-AW){1'b0}}, r_addr[r_head]} :
                          w_ld_miss ? ld_addr_i : '0;
    assign mem_wrdata_o = w_drain ? r_data[r_head] : '0;
    assign empty_o      = w_empty;
    assign full_o       = w_full;

    // Entry storage: allocate at tail, or merge into the youngest entry
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr_i[AW-1:0];
            r_data[r_tail] <= st_data_i;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        else if (st_valid_i && w_coal) begin
            r_data[w_tail_m1] <= st_data_i;
        end
`endif
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)  r_tail <= r_tail + PW'(1);
            if (w_drain) r_head <= r_head + PW'(1);
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Table-driven self-checking bench for store_buffer. Each row
//                holds one cycle of inputs and the outputs expected during
//                that cycle; rows run back to back so state carries over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        st_valid_i = 1'b0;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic        st_ready_o;
    logic        ld_valid_i = 1'b0;
    logic [31:0] ld_addr_i = '0;
    logic        ld_hit_o;
    logic        ld_stall_o;
    logic [31:0] ld_data_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wrdata_o;
    logic        mem_wr_o;
    logic        mem_rd_o;
    logic        empty_o;
    logic        full_o;

    store_buffer #(.DEPTH(4), .AW(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .st_valid_i   (st_valid_i),
        .st_addr_i    (st_addr_i),
        .st_data_i    (st_data_i),
        .st_ready_o   (st_ready_o),
        .ld_valid_i   (ld_valid_i),
        .ld_addr_i    (ld_addr_i),
        .ld_hit_o     (ld_hit_o),
        .ld_stall_o   (ld_stall_o),
        .ld_data_o    (ld_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wrdata_o (mem_wrdata_o),
        .mem_wr_o     (mem_wr_o),
        .mem_rd_o     (mem_rd_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    always #5 clk_i = ~clk_i;

    // flg = {st_ready, ld_hit, ld_stall, mem_wr, mem_rd, empty, full}
    typedef struct {
        logic        rst;
        logic        stv;
        logic [31:0] sta;
        logic [31:0] std;
        logic        ldv;
        logic [31:0] lda;
        logic [6:0]  flg;
        logic [31:0] ldd;
        logic [31:0] maddr;
        logic [31:0] mwd;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic rst, input logic stv,
                                input logic [31:0] sta, input logic [31:0] std,
                                input logic ldv, input logic [31:0] lda,
                                input logic [6:0] flg, input logic [31:0] ldd,
                                input logic [31:0] maddr, input logic [31:0] mwd);
        vec_t v;
        v.rst = rst; v.stv = stv; v.sta = sta; v.std = std;
        v.ldv = ldv; v.lda = lda; v.flg = flg; v.ldd = ldd;
        v.maddr = maddr; v.mwd = mwd;
        return v;
    endfunction

    task automatic apply(input int idx, input vec_t v);
        logic [102:0] got;
        logic [102:0] exp;
        @(posedge clk_i);
        #1;
        rst_i      = v.rst;
        st_valid_i = v.stv;
        st_addr_i  = v.sta;
        st_data_i  = v.std;
        ld_valid_i = v.ldv;
        ld_addr_i  = v.lda;
        @(negedge clk_i);
        got = {st_ready_o, ld_hit_o, ld_stall_o, mem_wr_o, mem_rd_o, empty_o, full_o,
               ld_data_o, mem_addr_o, mem_wrdata_o};
        exp = {v.flg, v.ldd, v.maddr, v.mwd};
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL vec%0d: got flg=%b ldd=%h maddr=%h mwd=%h, expected flg=%b ldd=%h maddr=%h mwd=%h",
                     idx, got[102:96], got[95:64], got[63:32], got[31:0],
                     exp[102:96], exp[95:64], exp[63:32], exp[31:0]);
        end
    endtask

    initial begin
        // ---- reset then idle ----
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1000010, 0, 32'h00, 32'h0));
        // ---- two stores drain in order on consecutive cycles ----
        tbl.push_back(mk(0,1,32'h10,32'hAABBCCDD, 0,32'h00, 7'b1000010, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h14,32'h11223344, 0,32'h00, 7'b1001000, 0, 32'h10, 32'hAABBCCDD));
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1001000, 0, 32'h14, 32'h11223344));
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1000010, 0, 32'h00, 32'h0));
        // ---- fill under continuous missing load, 5th store held ----
        tbl.push_back(mk(0,1,32'h08,32'h1,        1,32'h00, 7'b1000110, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h0C,32'h2,        1,32'h00, 7'b1000100, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h10,32'h3,        1,32'h00, 7'b1000100, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h14,32'h4,        1,32'h00, 7'b1000100, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h18,32'h5,        1,32'h00, 7'b0000101, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h18,32'h5,        0,32'h00, 7'b0001001, 0, 32'h08, 32'h1));
        tbl.push_back(mk(0,1,32'h18,32'h5,        0,32'h00, 7'b1001000, 0, 32'h0C, 32'h2));
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1001000, 0, 32'h10, 32'h3));
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1001000, 0, 32'h14, 32'h4));
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1001000, 0, 32'h18, 32'h5));
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1000010, 0, 32'h00, 32'h0));
        // ---- youngest exact match is forwarded ----
        tbl.push_back(mk(0,1,32'h08,32'h1,        1,32'h00, 7'b1000110, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h08,32'h2,        1,32'h00, 7'b1000100, 0, 32'h00, 32'h0));
`ifdef STORE_BUFFER_COALESCE_EN
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h08, 7'b1101000, 32'h2, 32'h08, 32'h2));
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h08, 7'b1000110, 0, 32'h08, 32'h0));
`else
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h08, 7'b1101000, 32'h2, 32'h08, 32'h1));
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h08, 7'b1101000, 32'h2, 32'h08, 32'h2));
`endif
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1000010, 0, 32'h00, 32'h0));
        // ---- overlap through address wrap; same-cycle store invisible ----
        tbl.push_back(mk(0,1,32'h1E,32'hDEAD,     1,32'h00, 7'b1000110, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h00, 7'b1011000, 0, 32'h1E, 32'hDEAD));
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h00, 7'b1000110, 0, 32'h00, 32'h0));
        // ---- overlap has priority over exact match ----
        tbl.push_back(mk(0,1,32'h04,32'h7,        1,32'h10, 7'b1000110, 0, 32'h10, 32'h0));
        tbl.push_back(mk(0,1,32'h06,32'h8,        1,32'h10, 7'b1000100, 0, 32'h10, 32'h0));
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h04, 7'b1011000, 0, 32'h04, 32'h7));
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h04, 7'b1011000, 0, 32'h06, 32'h8));
        tbl.push_back(mk(0,0,32'h00,32'h0,        1,32'h04, 7'b1000110, 0, 32'h04, 32'h0));
        // ---- full buffer, store to the youngest entry's address ----
        tbl.push_back(mk(0,1,32'h10,32'hA1,       1,32'h00, 7'b1000110, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h14,32'hB2,       1,32'h00, 7'b1000100, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h18,32'hC3,       1,32'h00, 7'b1000100, 0, 32'h00, 32'h0));
        tbl.push_back(mk(0,1,32'h0C,32'hD4,       1,32'h00, 7'b1000100, 0, 32'h00, 32'h0));
`ifdef STORE_BUFFER_COALESCE_EN
        tbl.push_back(mk(0,1,32'h0C,32'h55,       1,32'h00, 7'b1000101, 0, 32'h00, 32'h0));
`else
        tbl.push_back(mk(0,1,32'h0C,32'h55,       1,32'h00, 7'b0000101, 0, 32'h00, 32'h0));
`endif
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b0001001, 0, 32'h10, 32'hA1));
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1001000, 0, 32'h14, 32'hB2));
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1001000, 0, 32'h18, 32'hC3));
`ifdef STORE_BUFFER_COALESCE_EN
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1001000, 0, 32'h0C, 32'h55));
`else
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1001000, 0, 32'h0C, 32'hD4));
`endif
        tbl.push_back(mk(0,0,32'h00,32'h0,        0,32'h00, 7'b1000010, 0, 32'h00, 32'h0));

        // Power-on reset
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // Hand sequence: reset asserted in the middle of a drain discards
        // the entry in flight and the one enqueued in the same cycle.
        apply(100, mk(0,1,32'h04,32'h9, 0,32'h00, 7'b1000010, 0, 32'h00, 32'h0));
        apply(101, mk(1,1,32'h08,32'hA, 0,32'h00, 7'b1001000, 0, 32'h04, 32'h9));
        apply(102, mk(0,0,32'h00,32'h0, 0,32'h00, 7'b1000010, 0, 32'h00, 32'h0));
        apply(103, mk(0,0,32'h00,32'h0, 1,32'h04, 7'b1000110, 0, 32'h04, 32'h0));
        apply(104, mk(0,0,32'h00,32'h0, 1,32'h08, 7'b1000110, 0, 32'h08, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-back store queue directly upstream of the data memory, between the MEM pipeline stage and the data memory port.
- Accepts stores from the pipeline and holds them in a small FIFO.
- Drains one store per cycle to the data memory whenever the port is not needed by a load.
- Forwards buffered data to loads that exactly match a buffered address, and stalls loads that partially overlap a buffered store.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, 2..16)
- AW, 5, memory byte-address bits compared and driven (data memory decodes addr[4:0], wraps mod 32)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- st_valid_i  in  1  store request from MEM stage
- st_addr_i  in  32  store byte address
- st_data_i  in  32  store word (little-endian bytes)
- st_ready_o  out  1  store accepted this cycle when high with st_valid_i
- ld_valid_i  in  1  load request from MEM stage
- ld_addr_i  in  32  load byte address
- ld_hit_o  out  1  load served from buffer this cycle
- ld_stall_o  out  1  load must be held; pipeline freezes MEM stage
- ld_data_o  out  32  forwarded data, valid when ld_hit_o
- mem_addr_o  out  32  to data memory address
- mem_wrdata_o  out  32  to data memory write data
- mem_wr_o  out  1  to data memory write enable
- mem_rd_o  out  1  to data memory read enable
- empty_o  out  1  no entries buffered
- full_o  out  1  count == DEPTH

Behaviour:
- State:
  - DEPTH entries {addr[AW-1:0], data[31:0]}.
  - Head and tail pointers, each log2(DEPTH) bits, wrapping at DEPTH.
  - Count, log2(DEPTH)+1 bits.
- Reset: rst_i high at an edge sets count = 0 and pointers = 0, and discards all entries, including mid-drain.
  - Post-reset outputs: empty_o = 1, full_o = 0, st_ready_o = 1, mem_wr_o = 0, ld_hit_o = 0, ld_stall_o = 0, ld_data_o = 0.
- Enqueue:
  - st_ready_o = !full_o, combinational.
  - st_valid_i && st_ready_o writes the entry at tail, then tail++ and count++ at the edge.
  - No enqueue when full, even if a drain occurs in the same cycle.
- Load match: compare ld_addr_i[AW-1:0] against valid entries present at the start of the cycle only. A same-cycle store is not visible to the load.
  - Exact: entry addr == load addr. ld_hit_o = 1 and ld_data_o = data of the youngest exact match. mem_rd_o = 0.
  - Overlap: (load-entry) mod 2^AW or (entry-load) mod 2^AW is in {1,2,3}. ld_stall_o = 1 and ld_hit_o = 0. Overlap takes priority over exact match.
  - Miss: mem_rd_o = 1 and mem_addr_o = ld_addr_i.
- Drain:
  - drain = !empty && !(ld_valid_i && miss).
  - The buffer drains while a load hits or stalls, which guarantees progress.
  - On drain: mem_wr_o = 1, mem_addr_o = head addr (zero-extended), mem_wrdata_o = head data. Head and count update at the edge.
  - mem_wr_o and mem_rd_o are never high together.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- All outputs except stored state are combinational from inputs and the current state.
- Latency: a store is visible in data memory at the earliest on the edge after the cycle it was accepted.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined: a store whose addr[AW-1:0] equals the youngest entry's addr, where that entry is not the one draining this cycle, overwrites that entry's data in place.
  - No count change; accepted even when full.
  - st_ready_o = !full_o || coalesce_match.
- Undefined: every store allocates a new entry. No address comparison is made on the store path.

Test Plan:
- Reset then idle -> empty_o=1, st_ready_o=1, mem_wr_o=0, mem_rd_o=0.
- Stores 0x10<=0xAABBCCDD then 0x14<=0x11223344 with no loads -> mem_wr_o pulses on 2 consecutive cycles with addr 0x10 then 0x14, data in order; empty_o=1 afterwards.
- Fill 4 stores while ld_valid_i misses continuously (addr 0x00) -> full_o=1, st_ready_o=0, and a 5th store is held. Drop ld_valid_i -> drain resumes and st_ready_o=1 after the first drain.
- Buffer {0x08<=0x1, 0x08<=0x2}, load 0x08 -> ld_hit_o=1, ld_data_o=0x2 (youngest), mem_rd_o=0.
- Buffer 0x1E<=X, load 0x00 (overlap via wrap) -> ld_stall_o=1 until entry drains, then mem_rd_o=1 and the stall drops.
- With STORE_BUFFER_COALESCE_EN: full buffer, tail addr 0x0C, store 0x0C<=0x55 -> accepted, count stays 4, drained data for 0x0C = 0x55. Without the macro -> st_ready_o=0.
